tt_um_serial_subtractor: RTL and testbench
==========================================

// Module: tt_um_serial_subtractor
// PURPOSE
//  Bit-serial unsigned/two's-complement subtractor for the TT tile; inverse op and pin direction of the
//  combinational adder: operands are loaded byte-wise over ui_in, and control enters on uio_in[3:0].
//  Computes D = A - B LSB-first, one bit per enabled clock. D appears on uo_out.
//  Status (busy/done/borrow/overflow) is driven OUT on uio[7:4], so uio_oe is used in the output direction.
// PARAMETERS
//  WIDTH  8  operand width in bits, 1..8. ui_in bits above WIDTH are ignored; uo_out bits above WIDTH = 0.
// PORTS
//  clk      in   1  single clock, all state on rising edge
//  rst_n    in   1  synchronous active-low reset
//  ena      in   1  clock enable; low = hold all state
//  ui_in    in   8  operand data byte
//  uio_in   in   8  [0] load strobe, [1] operand select (0=A, 1=B), [2] start, [3] unused, [7:4] ignored
//  uo_out   out  8  result register D
//  uio_out  out  8  [3:0]=0, [4] busy, [5] done, [6] borrow (A<B unsigned), [7] signed overflow
//  uio_oe   out  8  constant 8'hF0 (uio[7:4] outputs, uio[3:0] inputs)
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): state=IDLE, A=B=0, D=0, busy=done=borrow=overflow=0; uio_oe stays 8'hF0.
//  - ena=0: no state, register or output changes; strobes are not sampled.
//  - Strobes are level-sampled at each enabled edge.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE/DONE: load=1 writes ui_in[WIDTH-1:0] into A or B per uio_in[1], and leaves the state unchanged.
//      start=1 with load=0 -> RUN. Entry clears done, sets busy, bit counter=0, borrow-in=0.
//      load=1 and start=1 in the same cycle: load is performed, start is ignored.
//    RUN: each enabled edge computes a full-subtract of A[i], B[i] and borrow-in, and shifts the diff bit into the
//      internal shift reg. A, B and D hold their values during RUN. load and start are ignored.
//      After WIDTH bit-cycles -> DONE: D <= result, borrow <= final borrow-out,
//      overflow <= (A[msb]!=B[msb]) && (D[msb]!=A[msb]), busy=0, done=1.
//    DONE: done, D and flags hold until the next start.
//  - Latency: start sampled at edge N -> busy=1 after N; done=1 and D valid after edge N+WIDTH.
//  - Arithmetic is modulo 2^WIDTH; the borrow flag is the unsigned underflow indicator.
//  - A=B gives D=0, borrow=0, overflow=0.
//  - Reset during RUN aborts: all outputs return to reset values in the next cycle, and no partial D is exposed.
// CONFIGURATION
//  SERIAL_SUB_SAT_EN defined: unsigned saturation. If the final borrow=1, D <= 0 (borrow flag is still set,
//    overflow still computed from the unsaturated result).
//  Not defined: wrap-around modulo 2^WIDTH result.
// TESTING
//  1. Reset, load A=0x50, B=0x20, start -> busy for 8 cycles; done=1 at start+8; uo_out=0x30, borrow=0, ovf=0.
//  2. A=0x10, B=0x20 -> uo_out=0xF0, borrow=1, ovf=0; with SERIAL_SUB_SAT_EN -> uo_out=0x00, borrow=1.
//  3. A=0x80, B=0x01 -> uo_out=0x7F, borrow=0, ovf=1; A=0x7F, B=0x7F -> 0x00, all flags 0.
//  4. During RUN, load B=0xFF and pulse start -> both ignored, result matches the original operands.
//     Load+start in the same IDLE cycle -> operand written, busy stays 0.
//  5. ena=0 for 3 cycles mid-RUN -> done is delayed by exactly 3 cycles, result unchanged.
//  6. rst_n=0 at bit-cycle 4 of RUN -> next cycle uo_out=0, uio_out=0x00, uio_oe=0xF0, state IDLE;
//     a fresh start then works normally.

Source files
------------

// File: rtl/tt_um_serial_subtractor.sv
// rtl/tt_um_serial_subtractor.sv - bit-serial subtractor D = A - B, LSB first; optional SERIAL_SUB_SAT_EN clamps underflow to 0
module tt_um_serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, d_q, sh_q;
    logic [CW-1:0]    cnt_q;
    logic             bin_q, busy_q, done_q, borrow_q, ovf_q;

    logic             load, sel, start;
    logic             abit_d, bbit_d, diff_d, bout_d;
    logic [WIDTH-1:0] sh_d;
    logic             unused_bits;

    assign load  = uio_in[0];
    assign sel   = uio_in[1];
    assign start = uio_in[2];
    assign unused_bits = &{1'b0, uio_in[7:3]};

    // Full subtractor on the current bit; diff shifts in at the top so the
    // register holds the complete LSB-first result after WIDTH steps.
    always_comb begin
        abit_d = a_q[cnt_q];
        bbit_d = b_q[cnt_q];
        diff_d = abit_d ^ bbit_d ^ bin_q;
        bout_d = (~abit_d & bbit_d) | (~(abit_d ^ bbit_d) & bin_q);
        sh_d   = (sh_q >> 1) | (WIDTH'(diff_d) << (WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            d_q      <= '0;
            sh_q     <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else if (ena) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (load) begin
                        if (sel) b_q <= ui_in[WIDTH-1:0];
                        else     a_q <= ui_in[WIDTH-1:0];
                    end else if (start) begin
                        state_q <= S_RUN;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        cnt_q   <= '0;
                        bin_q   <= 1'b0;
                    end
                end
                S_RUN: begin
                    sh_q  <= sh_d;
                    bin_q <= bout_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_q  <= S_DONE;
`ifdef SERIAL_SUB_SAT_EN
                        d_q      <= bout_d ? '0 : sh_d;
`else
                        d_q      <= sh_d;
`endif
                        borrow_q <= bout_d;
                        // Overflow always judged on the wrapped result
                        ovf_q    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sh_d[WIDTH-1] != a_q[WIDTH-1]);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign uo_out  = 8'(d_q);
    assign uio_out = {ovf_q, borrow_q, done_q, busy_q, 4'b0000};
    assign uio_oe  = 8'hF0;
endmodule

// File: tb/tb_tt_um_serial_subtractor.sv
// tb/tb_tt_um_serial_subtractor.sv - scoreboard bench for tt_um_serial_subtractor
module tb_tt_um_serial_subtractor;
    localparam int WIDTH = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    tt_um_serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
        .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       br;
        logic       ov;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_cnt = 0;
    logic prev_done = 1'b0;

    always @(posedge clk) cyc_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input int cyc);
        exp_t e;
        logic [7:0] wrap;
        wrap = a - b;
        e.br = (a < b);
        e.ov = (a[7] != b[7]) && (wrap[7] != a[7]);
`ifdef SERIAL_SUB_SAT_EN
        e.d = e.br ? 8'h00 : wrap;
`else
        e.d = wrap;
`endif
        e.cyc = cyc;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst_n && uio_out[5] && !prev_done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("d", uo_out, e.d);
                chk("borrow", uio_out[6], e.br);
                chk("ovf", uio_out[7], e.ov);
                chk("latency", cyc_cnt, e.cyc);
                chk("busy_at_done", uio_out[4], 0);
                chk("uio_low", uio_out[3:0], 0);
            end
        end
        prev_done = uio_out[5];
    end

    task automatic drive(input logic e, input logic [7:0] ctl, input logic [7:0] d);
        @(negedge clk);
        ena = e;
        uio_in = ctl;
        ui_in = d;
    endtask

    task automatic wait_empty();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 40) begin
            drive(1'b1, 8'h00, 8'h00);
            #1;
            k++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 0, 1);
            sb.delete();
        end
    endtask

    // Load A and B, start, optionally stall or inject ignored strobes mid-run.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                         input int stall_at, input int stall_len, input logic noise);
        logic [7:0] ctl;
        drive(1'b1, 8'h01, a);
        drive(1'b1, 8'h03, b);
        drive(1'b1, 8'h04, 8'h00);
        sb.push_back(model(a, b, cyc_cnt + 1 + WIDTH + stall_len));
        for (int k = 0; k < WIDTH + stall_len; k++) begin
            ctl = noise ? ((k % 2 == 1) ? 8'h04 : 8'h03) : 8'h00;
            drive((k >= stall_at && k < stall_at + stall_len) ? 1'b0 : 1'b1, ctl, 8'hFF);
            chk("busy_run", uio_out[4], 1);
        end
        drive(1'b1, 8'h00, 8'h00);
        #1;
        wait_empty();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_uo", uo_out, 8'h00);
        chk("rst_uio", uio_out, 8'h00);
        chk("rst_oe", uio_oe, 8'hF0);
        rst_n = 1'b1;

        // Operands reset to zero: start alone yields 0
        drive(1'b1, 8'h04, 8'h00);
        sb.push_back(model(8'h00, 8'h00, cyc_cnt + 1 + WIDTH));
        drive(1'b1, 8'h00, 8'h00);
        chk("busy_after_start", uio_out[4], 1);
        wait_empty();

        do_op(8'h50, 8'h20, 0, 0, 1'b0);
        do_op(8'h10, 8'h20, 0, 0, 1'b0);
        do_op(8'h80, 8'h01, 0, 0, 1'b0);
        do_op(8'h7F, 8'h7F, 0, 0, 1'b0);
        do_op(8'h00, 8'h01, 0, 0, 1'b0);
        do_op(8'hFF, 8'h00, 0, 0, 1'b0);

        // Strobes during RUN are ignored
        do_op(8'h33, 8'h11, 0, 0, 1'b1);

        // Load+start together: load wins, no run begins
        drive(1'b1, 8'h07, 8'h05);
        drive(1'b1, 8'h00, 8'h00);
        chk("ldstart_busy", uio_out[4], 0);
        chk("ldstart_done_hold", uio_out[5], 1);
        drive(1'b1, 8'h04, 8'h00);
        sb.push_back(model(8'h33, 8'h05, cyc_cnt + 1 + WIDTH));
        wait_empty();

        // Clock-enable stall mid-run delays done by exactly the stall
        do_op(8'hA5, 8'h3C, 3, 3, 1'b0);

        // Reset on the fourth bit cycle aborts the run
        drive(1'b1, 8'h01, 8'h5A);
        drive(1'b1, 8'h03, 8'h13);
        drive(1'b1, 8'h04, 8'h00);
        repeat (3) drive(1'b1, 8'h00, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_uo", uo_out, 8'h00);
        chk("abort_uio", uio_out, 8'h00);
        chk("abort_oe", uio_oe, 8'hF0);
        rst_n = 1'b1;
        repeat (WIDTH + 2) drive(1'b1, 8'h00, 8'h00);
        chk("abort_no_done", uio_out[5], 0);
        do_op(8'h5A, 8'h13, 0, 0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            do_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 0, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
